// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream source, chain and status signals of the chain loader
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              ok;

  modport master (
    output start, abort, data_in, data_valid, ccff_tail,
    input  data_ready, ccff_head, ccff_shift_en, busy, done, ok
  );

  modport slave (
    input  start, abort, data_in, data_valid, ccff_tail,
    output data_ready, ccff_head, ccff_shift_en, busy, done, ok
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - shifts a preamble plus CHAIN_LEN bitstream bits into a config chain
// and reports whether the preamble arrived intact at the chain tail.
module ccff_chain_loader #(
  parameter int          CHAIN_LEN = 36,
  parameter int          WORD_W    = 8,
  parameter int          PRE_LEN   = 8,
  parameter logic [31:0] PREAMBLE  = 32'h000000A5
) (
  input  logic prog_clk,
  input  logic prog_reset_n,
  ccff_chain_loader_if.slave bus
);

  localparam int TOTAL     = PRE_LEN + CHAIN_LEN;
  localparam int CNT_W     = $clog2(TOTAL + 1);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WCNT_W    = $clog2(NWORDS + 1);
  localparam int FILL_W    = $clog2(WORD_W + 1);
  localparam int LAST_BITS = ((CHAIN_LEN - 1) % WORD_W) + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_CHK      = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WORDS_ALL    = WCNT_W'(NWORDS);
  localparam logic [WCNT_W-1:0] WORDS_FINAL  = WCNT_W'(NWORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE     = WCNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_LAST    = FILL_W'(LAST_BITS - 1);
  localparam logic [FILL_W-1:0] FILL_ONE     = FILL_W'(1);
  // Preamble left-aligned so bit 31 is always the next bit to send or expect.
  localparam logic [31:0]       PRE_ALIGNED  = PREAMBLE << (32 - PRE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_LOAD, S_DONE} state_t;

  state_t              r_state,    w_state;
  logic [CNT_W-1:0]    r_cnt,      w_cnt;
  logic [WCNT_W-1:0]   r_words,    w_words;
  logic [FILL_W-1:0]   r_fill,     w_fill;
  logic [WORD_W-1:0]   r_buf,      w_buf;
  logic [31:0]         r_pre,      w_pre;
  logic [31:0]         r_chk,      w_chk;
  logic                r_head,     w_head;
  logic                r_shift_en, w_shift_en;
  logic                r_err,      w_err;
  logic                r_ok,       w_ok;
  logic                w_ready;
  logic                w_take;
  logic                w_chk_step;
  logic                w_mismatch;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_words    <= '0;
      r_fill     <= '0;
      r_buf      <= '0;
      r_pre      <= '0;
      r_chk      <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_err      <= 1'b0;
      r_ok       <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_words    <= w_words;
      r_fill     <= w_fill;
      r_buf      <= w_buf;
      r_pre      <= w_pre;
      r_chk      <= w_chk;
      r_head     <= w_head;
      r_shift_en <= w_shift_en;
      r_err      <= w_err;
      r_ok       <= w_ok;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_words    = r_words;
    w_fill     = r_fill;
    w_buf      = r_buf;
    w_pre      = r_pre;
    w_chk      = r_chk;
    w_head     = r_head;
    w_shift_en = r_shift_en;
    w_err      = r_err;
    w_ok       = r_ok;
    w_ready    = 1'b0;
    w_take     = 1'b0;

    // r_cnt counts completed shifts, so the shift in flight is r_cnt+1.
    w_chk_step = r_shift_en && (r_cnt >= CNT_CHK);
    w_mismatch = w_chk_step && (bus.ccff_tail != r_chk[31]);
    if (w_chk_step) begin
      w_chk = r_chk << 1;
      if (w_mismatch) w_err = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state    = S_PRE;
          w_cnt      = '0;
          w_words    = '0;
          w_fill     = '0;
          w_pre      = PRE_ALIGNED << 1;
          w_chk      = PRE_ALIGNED;
          w_head     = PRE_ALIGNED[31];
          w_shift_en = 1'b1;
          w_err      = 1'b0;
          w_ok       = 1'b0;
        end
      end
      S_PRE: begin
        w_ready = (r_cnt == CNT_PRE_LAST);
        if (bus.abort) begin
          w_state    = S_IDLE;
          w_shift_en = 1'b0;
          w_ok       = 1'b0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_PRE_LAST) begin
            w_state    = S_LOAD;
            w_take     = bus.data_valid;
            w_shift_en = bus.data_valid;
          end else begin
            w_head = r_pre[31];
            w_pre  = r_pre << 1;
          end
        end
      end
      S_LOAD: begin
        w_ready = (r_fill == '0) && (r_words != WORDS_ALL);
        if (bus.abort) begin
          w_state    = S_IDLE;
          w_shift_en = 1'b0;
          w_ok       = 1'b0;
        end else if (r_shift_en && (r_cnt == CNT_LAST)) begin
          w_cnt      = r_cnt + CNT_ONE;
          w_state    = S_DONE;
          w_shift_en = 1'b0;
          w_ok       = ~(r_err | w_mismatch);
        end else begin
          if (r_shift_en) w_cnt = r_cnt + CNT_ONE;
          if (r_fill != '0) begin
            w_head     = r_buf[WORD_W-1];
            w_buf      = r_buf << 1;
            w_fill     = r_fill - FILL_ONE;
            w_shift_en = 1'b1;
          end else begin
            // Empty buffer: shift only if a fresh word arrives, otherwise stall.
            w_take     = bus.data_valid && w_ready;
            w_shift_en = w_take;
          end
        end
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    if (w_take) begin
      w_head  = bus.data_in[WORD_W-1];
      w_buf   = bus.data_in << 1;
      w_fill  = (r_words == WORDS_FINAL) ? FILL_LAST : FILL_FULL;
      w_words = r_words + WCNT_ONE;
    end
  end

  assign bus.data_ready    = w_ready;
  assign bus.ccff_head     = r_head;
  assign bus.ccff_shift_en = r_shift_en;
  assign bus.busy          = (r_state == S_PRE) || (r_state == S_LOAD);
  assign bus.done          = (r_state == S_DONE);
  assign bus.ok            = r_ok;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench for ccff_chain_loader with a behavioural 36-flop chain
// and a per-cycle schedule model built from the word/stall plan.
module tb_ccff_chain_loader;
  localparam int P     = 8;
  localparam int N     = 36;
  localparam int W     = 8;
  localparam int NW    = 5;
  localparam int LASTB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccff_chain_loader_if #(.WORD_W(W)) bus();

  ccff_chain_loader #(
    .CHAIN_LEN(N), .WORD_W(W), .PRE_LEN(P), .PREAMBLE(32'h000000A5)
  ) dut (
    .prog_clk(clk),
    .prog_reset_n(rst_n),
    .bus(bus)
  );

  logic [N-1:0] chain = '0;
  int tail_mode = 0;
  always @(posedge clk) if (bus.ccff_shift_en) chain <= {chain[N-2:0], bus.ccff_head};
  assign bus.ccff_tail = (tail_mode == 1) ? 1'b0 : (tail_mode == 2) ? 1'b1 : chain[N-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [7:0] words [NW];
  int gap_cfg [NW];
  bit exp_en [64];
  bit exp_head [64];
  bit exp_rdy [64];
  bit exp_busy [64];
  bit exp_done [64];
  int exp_len = 0;
  int mon_end = 0;
  int t0 = 0;
  bit mon_on = 0;
  bit exp_ok = 0;
  int mon_rel;
  int n_en_tot = 0;
  int n_done_tot = 0;
  int last_done_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Expected per-cycle schedule: preamble, then per word its stall gap and its bits.
  task automatic build_model();
    int t;
    int nb;
    bit lh;
    logic [7:0] pre;
    logic [7:0] wd;
    pre = 8'hA5;
    for (int i = 0; i < 64; i++) begin
      exp_en[i] = 0; exp_head[i] = 0; exp_rdy[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
    end
    t = 1;
    for (int i = 0; i < P; i++) begin
      exp_en[t] = 1; exp_busy[t] = 1; exp_head[t] = pre[P-1-i]; t++;
    end
    lh = pre[0];
    for (int j = 0; j < NW; j++) begin
      exp_rdy[t-1] = 1;
      for (int g = 0; g < gap_cfg[j]; g++) begin
        exp_busy[t] = 1; exp_rdy[t] = 1; exp_head[t] = lh; t++;
      end
      nb = (j == NW - 1) ? LASTB : W;
      wd = words[j];
      for (int b = 0; b < nb; b++) begin
        exp_en[t] = 1; exp_busy[t] = 1; exp_head[t] = wd[W-1-b]; lh = wd[W-1-b]; t++;
      end
    end
    exp_done[t] = 1;
    exp_len = t;
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      n_done_tot++;
      last_done_cyc = cyc;
    end
    if (mon_on) begin
      mon_rel = cyc - t0;
      if (mon_rel >= 0 && mon_rel <= mon_end) begin
        chk($sformatf("shift_en@%0d", mon_rel), bus.ccff_shift_en, exp_en[mon_rel]);
        chk($sformatf("busy@%0d", mon_rel), bus.busy, exp_busy[mon_rel]);
        chk($sformatf("data_ready@%0d", mon_rel), bus.data_ready, exp_rdy[mon_rel]);
        chk($sformatf("done@%0d", mon_rel), bus.done, exp_done[mon_rel]);
        if (mon_rel >= 1 && exp_busy[mon_rel])
          chk($sformatf("head@%0d", mon_rel), bus.ccff_head, exp_head[mon_rel]);
        if (mon_rel >= 1)
          chk($sformatf("ok@%0d", mon_rel), bus.ok, (mon_rel == exp_len) ? exp_ok : 1'b0);
        if (bus.ccff_shift_en) n_en_tot++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, bus.data_ready, 0);
    chk({tag, "_head"}, bus.ccff_head, 0);
    chk({tag, "_shift_en"}, bus.ccff_shift_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ok"}, bus.ok, 0);
  endtask

  task automatic do_run(input int tmode, input int abort_at, input int rst_at,
                        input int bs1, input int bs2, input bit expok, input int done_lit);
    int widx;
    int gap_left;
    int hs;
    int en0;
    int dn0;
    int lim;
    bit stop;
    tail_mode = tmode;
    build_model();
    exp_ok = expok;
    widx = 0; gap_left = gap_cfg[0]; hs = 0; stop = 0;
    en0 = n_en_tot; dn0 = n_done_tot;
    mon_end = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : exp_len);
    lim = (abort_at >= 0) ? abort_at + 4 : exp_len + 2;
    for (int r = 0; r <= lim && !stop; r++) begin
      @(posedge clk); #1;
      if (r == 0) begin t0 = cyc; mon_on = 1; end
      bus.start = (r == 0) || (r == bs1) || (r == bs2);
      bus.abort = (r == abort_at);
      if (widx < NW) begin
        if (bus.data_ready && gap_left > 0) begin
          bus.data_valid = 1'b0;
          gap_left--;
        end else begin
          bus.data_valid = 1'b1;
          bus.data_in = words[widx];
        end
      end else begin
        bus.data_valid = 1'b0;
      end
      #1;
      if (bus.data_valid && bus.data_ready) begin
        hs++; widx++;
        if (widx < NW) gap_left = gap_cfg[widx];
      end
      if (abort_at >= 0 && r == abort_at + 1) begin
        chk("abort_shift_en", bus.ccff_shift_en, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ok", bus.ok, 0);
      end
      if (r == rst_at) begin
        @(negedge clk); #1;
        mon_on = 0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stop = 1;
      end
    end
    mon_on = 0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_valid = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_no_done", n_done_tot - dn0, 0);
    end else if (rst_at < 0) begin
      chk("done_cycle", last_done_cyc - t0, done_lit);
      chk("done_count", n_done_tot - dn0, 1);
      chk("shift_cycles", n_en_tot - en0, 44);
      chk("handshakes", hs, 5);
      if (tmode == 0) chk("chain", chain, 36'h123456789);
    end
  endtask

  initial begin
    words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9F};
    gap_cfg = '{0, 0, 0, 0, 0};
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    do_run(0, -1, -1, -1, -1, 1'b1, 45);
    do_run(1, -1, -1, -1, -1, 1'b0, 45);
    do_run(2, -1, -1, -1, -1, 1'b0, 45);
    gap_cfg = '{0, 3, 0, 0, 2};
    do_run(0, -1, -1, -1, -1, 1'b1, 50);
    gap_cfg = '{0, 0, 0, 0, 0};
    do_run(0, 20, -1, -1, -1, 1'b0, 0);
    do_run(0, -1, -1, -1, -1, 1'b1, 45);
    do_run(0, -1, 15, -1, -1, 1'b0, 0);
    do_run(0, -1, -1, -1, -1, 1'b1, 45);
    do_run(0, -1, -1, 5, 30, 1'b1, 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
